timer_input_cond: RTL and testbench

Input conditioner for one asynchronous timer input: synchronises it into the `clk` domain, rejects glitches shorter than a programmable qualification time, and produces a clean level plus a one-cycle edge pulse. It sits directly upstream of the general timer. Two instances are used:
- one drives `ext_meas_i` from `level_o`;
- one drives `capture_i` from `pulse_o`.

It also provides a saturating glitch counter for diagnostics.

---
 rtl/timer_pkg.sv | 27 ++
 rtl/timer_sync.sv | 23 ++
 rtl/timer_input_cond.sv | 127 ++++++++++++
 tb/tb_timer_input_cond.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the general timer and its input conditioners.
package timer_pkg;

    localparam int unsigned GLITCH_CNT_W = 8;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_sel_e;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        QUAL_HI   = 2'b01,
        STABLE_HI = 2'b10,
        QUAL_LO   = 2'b11
    } cond_state_e;

    function automatic logic edge_enabled(logic [1:0] sel, logic rising);
        if (rising) begin
            return sel inside {EDGE_RISE, EDGE_BOTH};
        end
        return sel inside {EDGE_FALL, EDGE_BOTH};
    endfunction

endpackage

// File: rtl/timer_sync.sv
// N-flop synchronizer for a single asynchronous bit; all flops reset to 0.
module timer_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/timer_input_cond.sv
// Timer input conditioner: synchronise, glitch-filter with a programmable
// qualification time, and emit a clean level, an edge pulse and a glitch count.
module timer_input_cond
    import timer_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    async_i,
    input  logic                    en,
    input  logic [FILT_W-1:0]       filt_len,
    input  logic [1:0]              edge_sel,
    input  logic                    glitch_clr,
    output logic                    level_o,
    output logic                    pulse_o,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt_o
);

    logic s;

    timer_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (async_i),
        .q_o (s)
    );

    cond_state_e             state_q, state_d;
    logic [FILT_W-1:0]       cnt_q, cnt_d;
    logic                    level_q, level_d;
    logic                    pulse_q, pulse_d;
    logic [GLITCH_CNT_W-1:0] gcnt_q, gcnt_d;
    logic                    reject;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        reject  = 1'b0;

        if (!en) begin
            // Park in the stable state matching the held level.
            state_d = level_q ? STABLE_HI : STABLE_LO;
            cnt_d   = '0;
        end else begin
            case (state_q)
                STABLE_LO: begin
                    if (s) begin
                        state_d = QUAL_HI;
                        cnt_d   = '0;
                    end
                end
                QUAL_HI: begin
                    if (!s) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                        reject  = 1'b1;
                    end else if (cnt_q >= filt_len) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        pulse_d = edge_enabled(edge_sel, 1'b1);
                    end else begin
                        // cnt_q < filt_len here, so the increment cannot wrap.
                        cnt_d = cnt_q + FILT_W'(1);
                    end
                end
                STABLE_HI: begin
                    if (!s) begin
                        state_d = QUAL_LO;
                        cnt_d   = '0;
                    end
                end
                QUAL_LO: begin
                    if (s) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                        reject  = 1'b1;
                    end else if (cnt_q >= filt_len) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                        level_d = 1'b0;
                        pulse_d = edge_enabled(edge_sel, 1'b0);
                    end else begin
                        cnt_d = cnt_q + FILT_W'(1);
                    end
                end
            endcase
        end
    end

    // Clear has priority over a rejection in the same cycle.
    always_comb begin
        gcnt_d = gcnt_q;
        if (glitch_clr) begin
            gcnt_d = '0;
        end else if (reject && (gcnt_q != '1)) begin
            gcnt_d = gcnt_q + GLITCH_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            gcnt_q  <= gcnt_d;
        end
    end

    assign level_o      = level_q;
    assign pulse_o      = pulse_q;
    assign glitch_cnt_o = gcnt_q;

endmodule

// File: tb/tb_timer_input_cond.sv
// Directed bench for timer_input_cond; expected outputs are queued per cycle
// when stimulus is applied and compared when that cycle's output is sampled.
module tb_timer_input_cond;
    import timer_pkg::*;

    localparam int unsigned FW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          async_i;
    logic          en;
    logic [FW-1:0] filt_len;
    logic [1:0]    edge_sel;
    logic          glitch_clr;
    logic          level_o;
    logic          pulse_o;
    logic [7:0]    glitch_cnt_o;

    timer_input_cond #(
        .SYNC_STAGES (2),
        .FILT_W      (FW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .async_i      (async_i),
        .en           (en),
        .filt_len     (filt_len),
        .edge_sel     (edge_sel),
        .glitch_clr   (glitch_clr),
        .level_o      (level_o),
        .pulse_o      (pulse_o),
        .glitch_cnt_o (glitch_cnt_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        string       tag;
        logic        level;
        logic        pulse;
        logic [7:0]  gcnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   pulses = 0;
    int   p0;

    // Sample away from the active edge and retire every expectation due by now.
    always @(negedge clk) begin
        if (pulse_o === 1'b1) pulses++;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            n_vec++;
            if (mon_e.cyc < cyc) begin
                n_err++;
                $error("FAIL %s: check for cycle %0d skipped, now at %0d", mon_e.tag, mon_e.cyc,
                       cyc);
            end else begin
                assert ({level_o, pulse_o, glitch_cnt_o} === {mon_e.level, mon_e.pulse, mon_e.gcnt})
                else begin
                    n_err++;
                    $error("FAIL %s @%0d: level/pulse/gcnt got %b/%b/%0d expected %b/%b/%0d",
                           mon_e.tag, cyc, level_o, pulse_o, glitch_cnt_o, mon_e.level,
                           mon_e.pulse, mon_e.gcnt);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int unsigned off, input string tag, input logic l,
                             input logic p, input logic [7:0] g);
        sb.push_back('{cyc + off, tag, l, p, g});
    endtask

    task automatic chk_now(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: level/pulse/gcnt got %b/%b/%0d expected %b/%b/%0d", tag, got[9],
                   got[8], got[7:0], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        async_i    = 1'b0;
        en         = 1'b0;
        filt_len   = '0;
        edge_sel   = EDGE_NONE;
        glitch_clr = 1'b0;
        #2;
        chk_now("reset_state", {level_o, pulse_o, glitch_cnt_o}, 10'd0);
        tick(2);
        rst      = 1'b0;
        en       = 1'b1;
        filt_len = 8'd3;
        edge_sel = EDGE_RISE;
        expect_at(1, "idle", 1'b0, 1'b0, 8'd0);
        tick(1);

        // Rising edge, filt_len=3: level/pulse appear on edge +7 after the change.
        async_i = 1'b1;
        expect_at(6, "rise_pre", 1'b0, 1'b0, 8'd0);
        expect_at(7, "rise_level", 1'b1, 1'b1, 8'd0);
        expect_at(8, "rise_pulse_w", 1'b1, 1'b0, 8'd0);
        tick(10);
        async_i = 1'b0;
        expect_at(6, "fall_pre", 1'b1, 1'b0, 8'd0);
        expect_at(7, "fall_nopulse", 1'b0, 1'b0, 8'd0);
        tick(10);

        // Two 3-clock glitches against filt_len=5.
        filt_len = 8'd5;
        p0       = pulses;
        async_i  = 1'b1;
        tick(3);
        async_i = 1'b0;
        expect_at(2, "g1_pre", 1'b0, 1'b0, 8'd0);
        expect_at(3, "g1", 1'b0, 1'b0, 8'd1);
        tick(5);
        async_i = 1'b1;
        tick(3);
        async_i = 1'b0;
        expect_at(3, "g2", 1'b0, 1'b0, 8'd2);
        tick(5);
        chk_int("glitch_no_pulse", pulses - p0, 0);
        glitch_clr = 1'b1;
        expect_at(1, "gclr", 1'b0, 1'b0, 8'd0);
        tick(1);
        glitch_clr = 1'b0;
        tick(2);

        // Both edges, filt_len=0: level follows input 4 edges later.
        filt_len = 8'd0;
        edge_sel = EDGE_BOTH;
        p0       = pulses;
        for (int i = 0; i < 3; i++) begin
            async_i = 1'b1;
            expect_at(3, "both_rise_pre", 1'b0, 1'b0, 8'd0);
            expect_at(4, "both_rise", 1'b1, 1'b1, 8'd0);
            expect_at(5, "both_rise_w", 1'b1, 1'b0, 8'd0);
            tick(4);
            async_i = 1'b0;
            expect_at(3, "both_fall_pre", 1'b1, 1'b0, 8'd0);
            expect_at(4, "both_fall", 1'b0, 1'b1, 8'd0);
            tick(4);
        end
        tick(6);
        chk_int("both_pulse_count", pulses - p0, 6);

        // 300 one-clock glitches saturate the counter.
        filt_len = 8'd10;
        edge_sel = EDGE_RISE;
        for (int i = 0; i < 300; i++) begin
            async_i = 1'b1;
            tick(1);
            async_i = 1'b0;
            tick(3);
        end
        expect_at(1, "sat", 1'b0, 1'b0, 8'd255);
        tick(1);
        async_i = 1'b1;
        tick(1);
        async_i = 1'b0;
        tick(2);
        expect_at(0, "sat_hold", 1'b0, 1'b0, 8'd255);
        glitch_clr = 1'b1;
        expect_at(1, "clr_wins", 1'b0, 1'b0, 8'd0);
        tick(1);
        glitch_clr = 1'b0;
        tick(3);

        // Drop enable mid-qualification, then re-enable with input still high.
        filt_len = 8'd5;
        async_i  = 1'b1;
        tick(4);
        en = 1'b0;
        expect_at(5, "en_off", 1'b0, 1'b0, 8'd0);
        expect_at(6, "en_off_hold", 1'b0, 1'b0, 8'd0);
        tick(8);
        filt_len = 8'd2;
        en       = 1'b1;
        expect_at(3, "reen_pre", 1'b0, 1'b0, 8'd0);
        expect_at(4, "reen_rise", 1'b1, 1'b1, 8'd0);
        tick(6);
        async_i = 1'b0;
        expect_at(5, "reen_fall_pre", 1'b1, 1'b0, 8'd0);
        expect_at(6, "reen_fall", 1'b0, 1'b0, 8'd0);
        tick(8);

        // Lower filt_len 20 -> 1 once cnt has reached 5.
        filt_len = 8'd20;
        async_i  = 1'b1;
        tick(8);
        filt_len = 8'd1;
        expect_at(0, "fl_pre", 1'b0, 1'b0, 8'd0);
        expect_at(1, "fl_accept", 1'b1, 1'b1, 8'd0);
        tick(3);
        async_i = 1'b0;
        tick(8);

        // Async reset in the middle of a pulse.
        filt_len = 8'd3;
        async_i  = 1'b1;
        tick(7);
        chk_now("pre_rst_pulse", {level_o, pulse_o, glitch_cnt_o}, {1'b1, 1'b1, 8'd0});
        #2;
        rst = 1'b1;
        #1;
        chk_now("rst_mid_pulse", {level_o, pulse_o, glitch_cnt_o}, 10'd0);
        tick(2);
        rst = 1'b0;
        tick(5);
        #2;
        rst = 1'b1;
        #1;
        chk_now("rst_mid_qual", {level_o, pulse_o, glitch_cnt_o}, 10'd0);
        tick(2);
        // Input held high through release qualifies as a normal rising edge.
        rst = 1'b0;
        expect_at(6, "post_rst_pre", 1'b0, 1'b0, 8'd0);
        expect_at(7, "post_rst_rise", 1'b1, 1'b1, 8'd0);
        expect_at(8, "post_rst_w", 1'b1, 1'b0, 8'd0);
        tick(10);

        chk_int("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
